arb_rr4: RTL and testbench
==========================

ARB_RR4 -- requirements
Module: arb_rr4

Interface
REQ-001 Parameter DATA_W, default 16, width of every data input and of out.
REQ-002 Parameter BURST, default 4, maximum number of transfers per grant (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  request vector; bit i = requester i (i = 0..3) wants the shared output.
REQ-006 in1, in2, in3, in4  input  DATA_W each  data of requesters 0, 1, 2, 3.
REQ-007 out_ready  input  1  downstream accepts out this cycle.
REQ-008 grant  output  4  one-hot grant, registered; all-zero when idle.
REQ-009 sel  output  2  registered index of the granted requester; drives the shared 4:1 select (00 -> in1 ... 11 -> in4).
REQ-010 out  output  DATA_W  selected data; combinational from sel and in1..in4.
REQ-011 out_valid  output  1  registered; high exactly when a grant is active.

Function
REQ-012 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant active).
REQ-013 A transfer SHALL occur on a cycle with out_valid = 1 and out_ready = 1.
REQ-014 Round-robin: a 2-bit pointer ptr SHALL mark the highest-priority requester; priority descends ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-015 In IDLE with req != 0, the next edge SHALL enter BUSY with grant = the winning one-hot bit, sel = its index, out_valid = 1; latency from request to grant is one cycle.
REQ-016 In IDLE with req = 0, grant, out_valid and ptr SHALL hold.
REQ-017 In BUSY, a 4-bit burst counter SHALL count transfers, cleared on every new grant.
REQ-018 A grant SHALL end at the edge where any one of these holds: transfer with counter = BURST-1; transfer while req[sel] = 0; or req[sel] = 0 with no transfer (abandoned, no data moved).
REQ-019 When a grant ends, ptr SHALL become sel+1 (mod 4).
REQ-020 When a grant ends and req has any bit set other than req[sel], the same edge SHALL issue the next grant from those other bits using the updated ptr, with no IDLE bubble.
REQ-021 When a grant ends and no other request is pending, the FSM SHALL return to IDLE (grant = 0, out_valid = 0).
REQ-022 In BUSY with no end condition, grant, sel and out_valid SHALL hold; out_ready low SHALL stall the grant indefinitely.
REQ-023 out SHALL equal the input selected by sel while out_valid = 1, and all-zero while out_valid = 0.
REQ-024 grant SHALL never have more than one bit set; sel SHALL always equal the index of the set grant bit while out_valid = 1.
REQ-025 Changes on req outside the granted bit SHALL NOT affect an active grant.

Reset
REQ-026 While rst_n = 0: state = IDLE, grant = 4'b0000, sel = 2'b00, out_valid = 0, out = 0, ptr = 0, burst counter = 0, applied immediately without a clock edge.
REQ-027 Reset asserted mid-burst SHALL drop the grant at once; after release, arbitration SHALL restart from ptr = 0.
REQ-028 The first edge after rst_n rises SHALL be a normal IDLE evaluation.

Verification
REQ-029 After reset, req = 4'b1010, out_ready = 1 -> next cycle grant = 4'b0010, sel = 01, out = in2; after 4 transfers grant moves to 4'b1000 with no idle cycle.
REQ-030 req = 4'b1111 held, out_ready = 1, BURST = 4 -> grant order 0,1,2,3,0, each exactly 4 cycles, out_valid continuously 1.
REQ-031 Grant to requester 2, out_ready = 0 for 10 cycles -> grant, sel = 10 and out = in3 stable; burst counter unchanged.
REQ-032 Requester 0 granted, drops req after 1 transfer, req = 4'b0001 -> 0 thereafter -> return to IDLE, out_valid = 0, out = 0, ptr = 1.
REQ-033 rst_n pulsed low mid-burst on requester 3 -> grant = 0, out_valid = 0 without a clock edge; after release with req = 4'b1001, first grant = 4'b0001.

Source files
------------

// File: rtl/arb_rr4.sv
// arb_rr4: four-requester round-robin arbiter with a burst limit and a shared 4:1 data mux.
module arb_rr4 #(
  parameter int DATA_W = 16,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic              out_ready,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel_n;
  logic [3:0] grant_n, cnt, cnt_n;
  logic [2:0] cand;
  logic       xfer, done;
  // scan from lowest to highest priority so the last hit wins; bit 2 flags a hit
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] k;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) pick = {1'b1, k};
    end
  endfunction
  always_comb begin
    xfer    = out_valid & out_ready;
    done    = (state == BUSY) && (!req[sel] || (xfer && cnt == 4'(BURST - 1)));
    ptr_n   = done ? sel + 2'd1 : ptr;
    cand    = pick(state == IDLE ? req : req & ~grant, ptr_n);
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    cnt_n   = cnt;
    if (state == IDLE || done) begin
      state_n = cand[2] ? BUSY : IDLE;
      grant_n = cand[2] ? 4'b0001 << cand[1:0] : 4'b0000;
      sel_n   = cand[2] ? cand[1:0] : sel;
      cnt_n   = 4'd0;
    end else begin
      cnt_n = cnt + 4'(xfer);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      sel       <= 2'b00;
      out_valid <= 1'b0;
      ptr       <= 2'd0;
      cnt       <= 4'd0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      sel       <= sel_n;
      out_valid <= (state_n == BUSY);
      ptr       <= ptr_n;
      cnt       <= cnt_n;
    end
  end
  always_comb
    out = !out_valid  ? '0  :
          sel == 2'd0 ? in1 :
          sel == 2'd1 ? in2 :
          sel == 2'd2 ? in3 : in4;
endmodule

// File: tb/tb_arb_rr4.sv
// tb_arb_rr4: directed scoreboard bench; stimulus queues expected transfers, a negedge monitor checks them.
module tb_arb_rr4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic        out_ready;
  logic [15:0] d [4];
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {logic [3:0] g; logic [1:0] s; logic [15:0] o;} exp_t;
  exp_t q[$];

  arb_rr4 #(.DATA_W(16), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in1(d[0]), .in2(d[1]), .in3(d[2]), .in4(d[3]),
    .out_ready(out_ready), .grant(grant), .sel(sel), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] idx(input logic [3:0] g);
    return g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // one cycle: g is the grant expected to be visible during this cycle
  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] g);
    exp_t e;
    @(posedge clk);
    #1;
    req = r;
    out_ready = rdy;
    #1;
    chk("grant", 32'(grant), 32'(g));
    chk("out_valid", 32'(out_valid), 32'(g != 4'b0000));
    if (g != 4'b0000 && rdy) begin
      e.g = g; e.s = idx(g); e.o = d[idx(g)];
      q.push_back(e);
    end else begin
      chk("out", 32'(out), g != 4'b0000 ? 32'(d[idx(g)]) : 32'd0);
      if (g != 4'b0000) chk("sel", 32'(sel), 32'(idx(g)));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_xfer: got grant %b with no transfer expected at %0t", grant, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xfer_grant", 32'(grant), 32'(e.g));
        chk("xfer_sel", 32'(sel), 32'(e.s));
        chk("xfer_out", 32'(out), 32'(e.o));
      end
    end
  end

  initial begin
    d = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1010 from ptr 0: requester 1 for 4 beats, then requester 3 without a bubble
    step(4'b1010, 1'b1, 4'b0000);
    repeat (4) step(4'b1010, 1'b1, 4'b0010);
    repeat (3) step(4'b1010, 1'b1, 4'b1000);
    step(4'b0000, 1'b1, 4'b1000);
    step(4'b0000, 1'b1, 4'b0000);

    // all requesting: 0,1,2,3,0 each for exactly 4 beats
    d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    step(4'b1111, 1'b1, 4'b0000);
    for (int k = 0; k < 5; k++)
      for (int b = 0; b < 4; b++)
        step((k == 4 && b == 3) ? 4'b0000 : 4'b1111, 1'b1, 4'b0001 << (k % 4));
    step(4'b0000, 1'b1, 4'b0000);

    // ptr = 1: requester 2 stalled 10 cycles while other bits toggle, then a full burst
    step(4'b0100, 1'b0, 4'b0000);
    for (int k = 0; k < 10; k++) step(k[0] ? 4'b0110 : 4'b0100, 1'b0, 4'b0100);
    step(4'b0100, 1'b0, 4'b0100);
    repeat (3) step(4'b0100, 1'b1, 4'b0100);
    step(4'b0000, 1'b1, 4'b0100);
    step(4'b0000, 1'b1, 4'b0000);

    // requester 0: one transfer, then abandons; ptr must become 1
    step(4'b0001, 1'b1, 4'b0000);
    step(4'b0001, 1'b1, 4'b0001);
    step(4'b0000, 1'b0, 4'b0001);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0011, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0010);
    step(4'b0000, 1'b1, 4'b0000);

    // async reset mid-burst on requester 3, then restart from ptr 0
    step(4'b1000, 1'b1, 4'b0000);
    repeat (2) step(4'b1000, 1'b1, 4'b1000);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; req = 4'b1001;
    step(4'b1001, 1'b1, 4'b0001);
    step(4'b0000, 1'b1, 4'b0001);
    step(4'b0000, 1'b1, 4'b0000);

    @(posedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
